// File: rtl/donut_march.sv
// Ray-march responder for the donut renderer: sphere-traces a torus with a
// shift-add CORDIC distance function and shades the hit with one extra evaluation.
module donut_march #(
    parameter int                 ITERS   = 12,
    parameter int                 R_MAJOR = 512,
    parameter int                 R_MINOR = 256,
    parameter int                 EPS     = 2,
    parameter logic signed [15:0] ESCAPE  = 16'sh3000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [15:0] pxin,
    input  logic signed [15:0] pyin,
    input  logic signed [15:0] pzin,
    input  logic signed [15:0] rxin,
    input  logic signed [15:0] ryin,
    input  logic signed [15:0] rzin,
    input  logic signed [15:0] lxin,
    input  logic signed [15:0] lyin,
    input  logic signed [15:0] lzin,
    output logic               busy,
    output logic               done,
    output logic               hit,
    output logic signed [15:0] light
);

    typedef enum logic [1:0] {IDLE, MARCH, SHADE} state_t;

    // Four vectoring rotations, then a 0.609375 gain trim built from shifts.
    function automatic logic signed [17:0] len2(input logic signed [17:0] x,
                                                input logic signed [17:0] y);
        logic signed [17:0] a;
        logic signed [17:0] b;
        logic signed [17:0] an;
        logic signed [17:0] bn;
        a = x[17] ? -x : x;
        b = y[17] ? -y : y;
        for (int i = 0; i < 4; i++) begin
            if (!b[17]) begin
                an = a + (b >>> i);
                bn = b - (a >>> i);
            end else begin
                an = a - (b >>> i);
                bn = b + (a >>> i);
            end
            a = an;
            b = bn;
        end
        return (a >>> 1) + (a >>> 3) - (a >>> 6);
    endfunction

    function automatic logic signed [15:0] sdf(input logic signed [15:0] x,
                                               input logic signed [15:0] y,
                                               input logic signed [15:0] z);
        logic signed [17:0] ring;
        ring = len2(18'(x), 18'(y)) - 18'(R_MAJOR);
        return 16'(len2(ring, 18'(z)) - 18'(R_MINOR));
    endfunction

    function automatic logic escaped(input logic signed [15:0] v);
        return (v >= ESCAPE) || (v <= -ESCAPE);
    endfunction

    // Direction is Q12, so the Q8 step is the product shifted back by 12.
    function automatic logic signed [15:0] advance(input logic signed [15:0] p,
                                                   input logic signed [15:0] d,
                                                   input logic signed [15:0] r);
        return p + 16'((32'(d) * 32'(r)) >>> 12);
    endfunction

    state_t             state_r;
    logic signed [15:0] px_r, py_r, pz_r;
    logic signed [15:0] rx_r, ry_r, rz_r;
    logic signed [15:0] lx_r, ly_r, lz_r;
    logic signed [15:0] d_r;
    logic        [3:0]  cnt_r;

    logic signed [15:0] d_s;
    logic signed [15:0] shade_s;
    logic               near_s;
    logic               last_s;

    assign d_s     = sdf(px_r, py_r, pz_r);
    assign shade_s = sdf(px_r + lx_r, py_r + ly_r, pz_r + lz_r) - d_r;
    assign near_s  = d_s < 16'(EPS);
    assign last_s  = (cnt_r == 4'(ITERS - 1)) ||
                     escaped(px_r) || escaped(py_r) || escaped(pz_r);

    // Query FSM: latch, march one evaluation per edge, shade once on a hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            px_r <= 16'sd0; py_r <= 16'sd0; pz_r <= 16'sd0;
            rx_r <= 16'sd0; ry_r <= 16'sd0; rz_r <= 16'sd0;
            lx_r <= 16'sd0; ly_r <= 16'sd0; lz_r <= 16'sd0;
            d_r   <= 16'sd0;
            cnt_r <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hit   <= 1'b0;
            light <= 16'sd0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        px_r <= pxin; py_r <= pyin; pz_r <= pzin;
                        rx_r <= rxin; ry_r <= ryin; rz_r <= rzin;
                        lx_r <= lxin; ly_r <= lyin; lz_r <= lzin;
                        cnt_r   <= 4'd0;
                        busy    <= 1'b1;
                        state_r <= MARCH;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MARCH: begin
                    if (near_s) begin
                        d_r     <= d_s;
                        state_r <= SHADE;
                    end else if (last_s) begin
                        hit     <= 1'b0;
                        light   <= 16'sd0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        px_r  <= advance(px_r, d_s, rx_r);
                        py_r  <= advance(py_r, d_s, ry_r);
                        pz_r  <= advance(pz_r, d_s, rz_r);
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                SHADE: begin
                    light   <= shade_s;
                    hit     <= 1'b1;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_donut_march.sv
// Scoreboard bench for donut_march: stimulus pushes expected results, a monitor
// pops and compares them on every done strobe.
module tb_donut_march;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic signed [15:0] pxin, pyin, pzin, rxin, ryin, rzin, lxin, lyin, lzin;
    logic               busy, done, hit;
    logic signed [15:0] light;

    donut_march dut (
        .clk(clk), .rst(rst), .start(start),
        .pxin(pxin), .pyin(pyin), .pzin(pzin),
        .rxin(rxin), .ryin(ryin), .rzin(rzin),
        .lxin(lxin), .lyin(lyin), .lzin(lzin),
        .busy(busy), .done(done), .hit(hit), .light(light)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string name;
        int    exp_hit;
        int    exp_light;
        int    tol;
        int    start_cyc;
        int    min_lat;
        int    max_lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input int act, input int req, input int tol);
        tests++;
        if (act < req - tol || act > req + tol) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (+/-%0d) at cycle %0d", name, act, req, tol, cyc);
        end
    endtask

    task automatic launch(input string name,
                          input int ppx, input int ppy, input int ppz,
                          input int prx, input int pry, input int prz,
                          input int plx, input int ply, input int plz,
                          input int accept, input int ehit, input int elight,
                          input int tol, input int minl, input int maxl);
        exp_t e;
        pxin = 16'(ppx); pyin = 16'(ppy); pzin = 16'(ppz);
        rxin = 16'(prx); ryin = 16'(pry); rzin = 16'(prz);
        lxin = 16'(plx); lyin = 16'(ply); lzin = 16'(plz);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, "_busy"}, int'(busy), accept, 0);
        if (accept != 0) begin
            e.name = name; e.exp_hit = ehit; e.exp_light = elight; e.tol = tol;
            e.start_cyc = cyc; e.min_lat = minl; e.max_lat = maxl;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic direct_q(input string name);
        launch(name, 512, 0, -1280, 0, 0, 4096, 0, 0, -1024, 1, 1, 1024, 8, 3, 3);
    endtask

    task automatic hole_q(input string name);
        launch(name, 0, 0, -1280, 0, 0, 4096, 0, 0, -1024, 1, 0, 0, 0, 2, 12);
    endtask

    // Monitor: compare on done, otherwise results must hold their last value.
    initial begin
        exp_t               e;
        int                 lat;
        logic               last_hit;
        logic signed [15:0] last_light;
        last_hit   = 1'b0;
        last_light = 16'sd0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                last_hit   = 1'b0;
                last_light = 16'sd0;
            end else if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0, 0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_hit"}, int'(hit), e.exp_hit, 0);
                    check({e.name, "_light"}, int'(light), e.exp_light, e.tol);
                    lat = cyc - e.start_cyc;
                    tests++;
                    if (lat < e.min_lat || lat > e.max_lat) begin
                        fails++;
                        $display("FAIL %s_latency: got %0d edges, required %0d..%0d",
                                 e.name, lat, e.min_lat, e.max_lat);
                    end
                end
                last_hit   = hit;
                last_light = light;
            end else begin
                check("hold_hit", int'(hit), int'(last_hit), 0);
                check("hold_light", int'(light), int'(last_light), 0);
            end
        end
    end

    initial begin
        pxin = 16'sd0; pyin = 16'sd0; pzin = 16'sd0;
        rxin = 16'sd0; ryin = 16'sd0; rzin = 16'sd0;
        lxin = 16'sd0; lyin = 16'sd0; lzin = 16'sd0;
        repeat (2) @(negedge clk);
        check("reset_busy", int'(busy), 0, 0);
        check("reset_done", int'(done), 0, 0);
        check("reset_hit", int'(hit), 0, 0);
        check("reset_light", int'(light), 0, 0);
        rst = 1'b0;
        @(negedge clk);

        direct_q("direct");
        repeat (15) @(negedge clk);
        launch("immediate", 768, 0, 0, 4096, 0, 0, 256, 0, 0, 1, 1, 256, 8, 2, 2);
        repeat (15) @(negedge clk);
        hole_q("hole");
        repeat (15) @(negedge clk);

        // Start at edge 3 is ignored; start alongside done is accepted.
        direct_q("direct2");
        repeat (2) @(negedge clk);
        launch("ignored", 0, 0, -1280, 0, 0, 4096, 0, 0, -1024, 0, 0, 0, 0, 0, 0);
        launch("on_done", 768, 0, 0, 4096, 0, 0, 256, 0, 0, 1, 1, 256, 8, 2, 2);
        repeat (15) @(negedge clk);

        // Reset in the middle of a query aborts it with no done.
        direct_q("aborted");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0, 0);
        check("abort_done", int'(done), 0, 0);
        check("abort_hit", int'(hit), 0, 0);
        check("abort_light", int'(light), 0, 0);
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_idle_busy", int'(busy), 0, 0);

        for (int q = 0; q < 64; q++) begin
            check("cadence_idle", int'(busy), 0, 0);
            if (q % 2 == 0) direct_q("cad_direct");
            else hole_q("cad_hole");
            repeat (15) @(negedge clk);
        end

        repeat (20) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/donut_march.md
Name: donut_march

Overview:
- Ray-march responder on the donut renderer's per-pixel query interface.
- Accepts one query per start pulse: ray origin p, ray direction r and light vector l. Returns hit and a signed light value.
- Sphere-traces a torus with a shift-add CORDIC distance function, then shades the hit with one extra distance evaluation.
- Sized so a query finishes inside the renderer's 16-clock query cadence.

Parameters:
- ITERS, 12, maximum distance evaluations per query (2..13).
- R_MAJOR, 512, torus major radius, Q8 (2.0).
- R_MINOR, 256, torus minor radius, Q8 (1.0).
- EPS, 2, hit threshold on distance, Q8.
- ESCAPE, 16'sh3000, abs bound on any p component; beyond it the ray is a miss.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  single-cycle query strobe
- pxin/pyin/pzin  in  16 each  signed ray origin, Q8
- rxin/ryin/rzin  in  16 each  signed ray direction, Q12, approximately unit length
- lxin/lyin/lzin  in  16 each  signed light offset, Q8
- busy  out  1  query in progress
- done  out  1  one-cycle result strobe
- hit  out  1  surface hit flag, registered
- light  out  16  signed shade value, Q8, registered

Behaviour:
- One clock domain; reset is asynchronous and active-high. Reset forces state=IDLE, busy=0, done=0, hit=0, light=0 and clears all internal registers.
- States: IDLE, MARCH, SHADE.
- IDLE: start=1 at edge 0 latches p, r, l. It also clears the iteration counter, sets busy=1 and goes to MARCH.
- start while busy=1 is ignored. start is accepted in the cycle done=1, because busy is already 0.
- len2(x,y):
  - Take a=|x|, b=|y|, 18-bit signed internal.
  - Run 4 vectoring stages i=0..3, all using pre-stage values: if b>=0 then a+=b>>>i, b-=a>>>i; else a-=b>>>i, b+=a>>>i.
  - Result = (a>>>1)+(a>>>3)-(a>>>6), which is gain compensation of 0.609375.
- sdf(p) = len2(len2(px,py)-R_MAJOR, pz) - R_MINOR. Fully combinational, 18-bit internal, truncated to 16 bits signed.
- MARCH, one evaluation per edge k=1..ITERS, computes d=sdf(p):
  - d<EPS (signed): p holds, d is stored, next state is SHADE.
  - Else, if k==ITERS or any |p component| >= ESCAPE: hit<=0, light<=0, done<=1, busy<=0, next state is IDLE.
  - Else: p += (d*r)>>>12 per component, using a 16x16 signed product, 32-bit internal, low 16 bits kept.
- SHADE, one edge: light <= sdf(p+l) - d_stored, with 16-bit wrap on p+l. Also hit<=1, done<=1, busy<=0, next state is IDLE.
- Latency from the start edge to done high:
  - hit at evaluation k: k+1 edges;
  - miss at evaluation k: k edges;
  - maximum ITERS+1 = 13 edges at default.
- done is high exactly one cycle. hit and light hold stable until the next done, so consumers may sample them at any time.
- Reset mid-query aborts immediately; no done is emitted.

Test Plan:
- Reset: rst=1 during a query → busy=0, done=0, hit=0, light=0 immediately. After release the module stays IDLE with no done.
- Direct hit: p=(512,0,-1280), r=(0,0,4096), l=(0,0,-1024), start.
  - First d ≈ 1024 (±4), second d < EPS.
  - Required: done at edge 3, hit=1, light ≈ +1024 (±8).
- Hole miss: p=(0,0,-1280), r=(0,0,4096), start.
  - d never drops below ≈ 250.
  - Required: done at or before edge 12, hit=0, light=0.
- Immediate hit: p=(768,0,0) (d≈0), r=(4096,0,0), l=(256,0,0), start → done at edge 2, hit=1, light ≈ +256 (±8).
- Ignored start: pulse start again at edge 3 of the direct-hit query → only one done, results unchanged. A start coinciding with done is accepted and busy rises on the next edge.
- Cadence: issue the direct-hit and hole-miss queries alternately every 16 clocks for 64 queries → every done arrives before the next start, and hit alternates 1,0.
